// File: rtl/cbc_dec_sequencer.sv
// cbc_dec_sequencer: control and chaining sequencer for AES-128 CBC decryption.
// Feeds ciphertext blocks to a fixed-latency, non-stallable decrypt core and
// XORs each core result with the IV or the previous ciphertext block. All
// chaining state lives here, so the core stays a pure block transform.
module cbc_dec_sequencer #(
    parameter int CORE_LAT  = 1,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iv_load,
    input  logic [127:0]         iv_in,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [127:0]         s_data,
    input  logic                 s_last,
    output logic [127:0]         core_data_in,
    output logic                 core_start,
    input  logic [127:0]         core_data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [127:0]         m_data,
    output logic                 m_last,
    output logic [BLK_CNT_W-1:0] blk_count,
    output logic                 busy,
    output logic                 iv_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [3:0]           LAT_INIT = 4'(CORE_LAT);
    localparam logic [BLK_CNT_W-1:0] CNT_ONE  = BLK_CNT_W'(1);

    state_t       state;
    logic [127:0] prev_cb;   // IV or previous ciphertext block
    logic [127:0] cur_cb;    // block currently held at the core input
    logic [3:0]   lat_cnt;   // cycles remaining until the core result is valid
    logic         last_r;    // s_last of the block in flight

    // Handshake and status outputs decoded from registered state; s_valid never reaches s_ready.
    always_comb begin
        s_ready      = (state == ACCEPT) && !iv_load;
        m_valid      = (state == OUT);
        busy         = (state == WAIT) || (state == OUT);
        core_start   = (state == WAIT) && (lat_cnt == LAT_INIT);
        core_data_in = cur_cb;
    end

    // Sequencer FSM with all chaining, output and status registers.
    // NOTE: every register here uses <= so all updates see pre-edge values, which
    // is what lets prev_cb move to cur_cb in the same edge that m_data uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev_cb   <= '0;
            cur_cb    <= '0;
            lat_cnt   <= '0;
            last_r    <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            blk_count <= '0;
            iv_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iv_load) begin
                        prev_cb   <= iv_in;
                        blk_count <= '0;
                        iv_err    <= 1'b0;
                        state     <= ACCEPT;
                    end
                end

                ACCEPT: begin
                    // A new IV wins over a block offered in the same cycle.
                    if (iv_load) begin
                        prev_cb   <= iv_in;
                        blk_count <= '0;
                        iv_err    <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        cur_cb  <= s_data;
                        last_r  <= s_last;
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    // An IV arriving mid-block is refused; the chain keeps its old prev_cb.
                    if (iv_load) begin
                        iv_err <= 1'b1;
                    end
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        m_data  <= core_data_out ^ prev_cb;
                        m_last  <= last_r;
                        prev_cb <= cur_cb;
                        state   <= OUT;
                    end
                end

                OUT: begin
                    if (iv_load) begin
                        iv_err <= 1'b1;
                    end
                    if (m_ready) begin
                        blk_count <= blk_count + CNT_ONE;
                        state     <= m_last ? IDLE : ACCEPT;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbc_dec_sequencer.sv
// tb_cbc_dec_sequencer: scoreboard bench for cbc_dec_sequencer. Two instances
// (core latency 1 with a 16-bit counter, core latency 3 with a 2-bit counter)
// share the stimulus; 'sel' routes valid/iv_load to one and picks its outputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_cbc_dec_sequencer;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         iv_load = 1'b0;
    logic [127:0] iv_in = '0;
    logic         s_valid = 1'b0;
    logic [127:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b0;

    // Instance with CORE_LAT=1
    logic         s_valid1, iv_load1, s_ready1, cs1, m_valid1, m_last1, busy1, ie1;
    logic [127:0] cdi1, cout1, m_data1;
    logic [15:0]  bc1;
    // Instance with CORE_LAT=3
    logic         s_valid3, iv_load3, s_ready3, cs3, m_valid3, m_last3, busy3, ie3;
    logic [127:0] cdi3, cout3, m_data3;
    logic [1:0]   bc3;
    logic [127:0] p3 [3];

    // Selected view
    logic         s_ready, mv, m_last, cs, busy, ie;
    logic [127:0] m_data, cdi;
    logic [15:0]  bc;

    exp_t         sb[$];
    logic [127:0] exp_prev = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    assign s_valid1 = s_valid & ~sel;
    assign iv_load1 = iv_load & ~sel;
    assign s_valid3 = s_valid & sel;
    assign iv_load3 = iv_load & sel;

    assign s_ready = sel ? s_ready3 : s_ready1;
    assign mv      = sel ? m_valid3 : m_valid1;
    assign m_last  = sel ? m_last3  : m_last1;
    assign cs      = sel ? cs3      : cs1;
    assign busy    = sel ? busy3    : busy1;
    assign ie      = sel ? ie3      : ie1;
    assign m_data  = sel ? m_data3  : m_data1;
    assign cdi     = sel ? cdi3     : cdi1;
    assign bc      = sel ? {14'd0, bc3} : bc1;

    always #5 clk = ~clk;

    // Pass-through core models: registered, latency 1 and 3
    always @(posedge clk) cout1 <= cdi1;
    always @(posedge clk) begin
        p3[0] <= cdi3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign cout3 = p3[2];

    cbc_dec_sequencer #(.CORE_LAT(1), .BLK_CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .iv_load(iv_load1), .iv_in(iv_in),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
        .core_data_in(cdi1), .core_start(cs1), .core_data_out(cout1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
        .blk_count(bc1), .busy(busy1), .iv_err(ie1)
    );

    cbc_dec_sequencer #(.CORE_LAT(3), .BLK_CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .iv_load(iv_load3), .iv_in(iv_in),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data), .s_last(s_last),
        .core_data_in(cdi3), .core_start(cs3), .core_data_out(cout3),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .m_last(m_last3),
        .blk_count(bc3), .busy(busy3), .iv_err(ie3)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && mv && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("m_data", m_data, e.data);
                check("m_last", {127'd0, m_last}, {127'd0, e.last});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Load a new IV in IDLE/ACCEPT; the model chain restarts from it
    task automatic load_iv(input logic [127:0] v);
        tick;
        iv_load = 1'b1;
        iv_in   = v;
        tick;
        iv_load = 1'b0;
        exp_prev = v;
    endtask

    // Offer one block until accepted; returns 1 time unit after the accept edge
    task automatic send_block(input logic [127:0] cb, input logic last);
        bit got = 1'b0;
        tick;
        s_valid = 1'b1;
        s_data  = cb;
        s_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            got = s_ready;
            tick;
            if (got) break;
        end
        s_valid = 1'b0;
        check("accept_done", {127'd0, got}, 128'd1);
        if (got) begin
            sb.push_back('{data: cb ^ exp_prev, last: last});
            exp_prev = cb;
            check("core_data_in", cdi, cb);
        end
    endtask

    // From just after the accept edge: edges until m_valid, and core_start pulses seen
    task automatic measure(input int exp_lat);
        int j  = 0;
        int np = 0;
        @(negedge clk);
        if (cs) np++;
        while (!mv && j < 40) begin
            @(negedge clk);
            j++;
            if (cs) np++;
        end
        check("latency", 128'(j), 128'(exp_lat));
        check("core_start_pulses", 128'(np), 128'd1);
    endtask

    // Wait for every expected block to be delivered
    task automatic drain;
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mv) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", {127'd0, done}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        logic [127:0] c;

        // Reset state
        #12;
        check("rst_s_ready",   {127'd0, s_ready}, 128'd0);
        check("rst_m_valid",   {127'd0, mv},      128'd0);
        check("rst_m_data",    m_data,            128'd0);
        check("rst_m_last",    {127'd0, m_last},  128'd0);
        check("rst_core_in",   cdi,               128'd0);
        check("rst_core_start",{127'd0, cs},      128'd0);
        check("rst_blk_count", {112'd0, bc},      128'd0);
        check("rst_busy",      {127'd0, busy},    128'd0);
        check("rst_iv_err",    {127'd0, ie},      128'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", {127'd0, s_ready}, 128'd0);

        // 1. Chaining with CORE_LAT=1
        m_ready = 1'b1;
        load_iv(128'h01);
        send_block(128'h10, 1'b0);
        measure(2);
        check("sc1_pt0", m_data, 128'h11);
        drain;
        send_block(128'hF0, 1'b0);
        measure(2);
        check("sc1_pt1", m_data, 128'hE0);
        drain;
        check("sc1_blk_count", {112'd0, bc}, 128'd2);

        // 2. Backpressure during OUT
        tick;
        m_ready = 1'b0;
        send_block(rnd128(), 1'b0);
        measure(2);
        held = m_data;
        tick;
        s_valid = 1'b1;
        s_data  = rnd128();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_valid", {127'd0, mv},      128'd1);
            check("bp_m_data",  m_data,            held);
            check("bp_s_ready", {127'd0, s_ready}, 128'd0);
        end
        tick;
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain;
        send_block(rnd128(), 1'b0);
        drain;
        check("bp_blk_count", {112'd0, bc}, 128'd4);

        // 3. Last block, then a fresh message
        send_block(rnd128(), 1'b1);
        drain;
        tick;
        s_valid = 1'b1;
        s_data  = rnd128();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_last_s_ready", {127'd0, s_ready}, 128'd0);
            check("post_last_busy",    {127'd0, busy},    128'd0);
        end
        tick;
        s_valid = 1'b0;
        load_iv(rnd128());
        send_block(rnd128(), 1'b1);
        drain;
        check("msg2_blk_count", {112'd0, bc}, 128'd1);

        // 4. IV load while a block is in flight
        load_iv(rnd128());
        send_block(rnd128(), 1'b0);
        iv_load = 1'b1;
        iv_in   = rnd128();
        tick;
        iv_load = 1'b0;
        @(negedge clk);
        check("iv_err_set", {127'd0, ie}, 128'd1);
        drain;
        send_block(rnd128(), 1'b0);
        drain;
        check("iv_err_sticky", {127'd0, ie}, 128'd1);
        load_iv(rnd128());
        @(negedge clk);
        check("iv_err_clear",  {127'd0, ie},      128'd0);
        check("blk_count_clr", {112'd0, bc},      128'd0);
        send_block(rnd128(), 1'b1);
        drain;

        // 5. CORE_LAT=3 instance: latency, core_start, 2-bit counter wrap
        tick;
        sel = 1'b1;
        load_iv(rnd128());
        for (int b = 0; b < 5; b++) begin
            c = rnd128();
            send_block(c, (b == 4));
            measure(4);
            drain;
        end
        check("wrap_blk_count", {112'd0, bc}, 128'd1);
        tick;
        sel = 1'b0;

        // 6. Asynchronous reset while in WAIT
        load_iv(rnd128());
        send_block(rnd128(), 1'b0);
        iv_load = 1'b1;
        iv_in   = rnd128();
        tick;
        iv_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_s_ready",   {127'd0, s_ready}, 128'd0);
        check("arst_m_valid",   {127'd0, mv},      128'd0);
        check("arst_m_data",    m_data,            128'd0);
        check("arst_core_in",   cdi,               128'd0);
        check("arst_core_start",{127'd0, cs},      128'd0);
        check("arst_busy",      {127'd0, busy},    128'd0);
        check("arst_iv_err",    {127'd0, ie},      128'd0);
        sb.delete();
        #3 rst_n = 1'b1;
        tick;
        s_valid = 1'b1;
        s_data  = rnd128();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_s_ready", {127'd0, s_ready}, 128'd0);
            check("post_rst_m_valid", {127'd0, mv},      128'd0);
        end
        tick;
        s_valid = 1'b0;
        load_iv(rnd128());
        send_block(rnd128(), 1'b0);
        send_block(rnd128(), 1'b1);
        drain;
        check("final_blk_count", {112'd0, bc}, 128'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
